// File: rtl/sine_reader_pkg.sv
// Shared types, default widths and the phase-to-address helper for the sine table reader.
package sine_reader_pkg;

    localparam int unsigned DefPhaseW = 32;
    localparam int unsigned DefAddrW  = 16;
    localparam int unsigned DefDataW  = 8;
    localparam int unsigned DefMissW  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StValid
    } state_e;

    // Top addr_w bits of a phase_w-wide phase; valid for phase_w <= 64, addr_w < 64.
    function automatic logic [63:0] phase_to_addr(input logic [63:0] phase,
                                                  input int unsigned phase_w,
                                                  input int unsigned addr_w);
        return (phase >> (phase_w - addr_w)) & ((64'd1 << addr_w) - 64'd1);
    endfunction

endpackage

// File: rtl/sine_table_reader_if.sv
// Sine RAM address/data side plus the outgoing sample stream of the table reader.
interface sine_table_reader_if
    import sine_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW
);

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output mem_addr,
        input  mem_data,
        output sample,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  mem_addr,
        output mem_data,
        input  sample,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/phase_accumulator.sv
// DDS phase accumulator: holds phase and increment, steps on strobe, wraps silently.
module phase_accumulator
    import sine_reader_pkg::*;
#(
    parameter int unsigned PHASE_W = DefPhaseW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    input  logic [PHASE_W-1:0] tune_word,
    input  logic               tune_load,
    input  logic               phase_clr,
    output logic [PHASE_W-1:0] phase
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] inc_q;
    logic [PHASE_W-1:0] base;

    // A clear coinciding with a step makes the step start from zero.
    always_comb begin
        base    = phase_clr ? '0 : phase_q;
        phase_d = step ? base + inc_q : base;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            inc_q   <= '0;
        end else begin
            phase_q <= phase_d;
            if (tune_load) begin
                inc_q <= tune_word;
            end
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/sine_table_reader.sv
// Tick-paced DDS reader of a combinational sine RAM with a valid/ready sample output.
// Define SINE_READER_PHASE_OFFSET_EN to add the phase_off address offset input.
module sine_table_reader
    import sine_reader_pkg::*;
#(
    parameter int unsigned PHASE_W = DefPhaseW,
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned MISS_W  = DefMissW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sample_tick,
    input  logic [PHASE_W-1:0]    tune_word,
    input  logic                  tune_load,
    input  logic                  phase_clr,
`ifdef SINE_READER_PHASE_OFFSET_EN
    input  logic [ADDR_W-1:0]     phase_off,
`endif
    sine_table_reader_if.master   bus,
    output logic [MISS_W-1:0]     missed
);

    state_e              state_q, state_d;
    logic                step;
    logic                miss_inc;
    logic                accept;
    logic [PHASE_W-1:0]  phase;
    logic [PHASE_W-1:0]  step_phase;
    logic [ADDR_W-1:0]   addr_calc;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic                valid_q, valid_d;
    logic [MISS_W-1:0]   missed_q, missed_d;

    phase_accumulator #(
        .PHASE_W (PHASE_W)
    ) u_phase_accumulator (
        .clk       (clk),
        .rst       (rst),
        .step      (step),
        .tune_word (tune_word),
        .tune_load (tune_load),
        .phase_clr (phase_clr),
        .phase     (phase)
    );

    assign accept     = sample_tick & en;
    assign step_phase = phase_clr ? '0 : phase;

`ifdef SINE_READER_PHASE_OFFSET_EN
    assign addr_calc = ADDR_W'(phase_to_addr(64'(step_phase), PHASE_W, ADDR_W)) + phase_off;
`else
    assign addr_calc = ADDR_W'(phase_to_addr(64'(step_phase), PHASE_W, ADDR_W));
`endif

    always_comb begin
        state_d  = state_q;
        step     = 1'b0;
        miss_inc = 1'b0;
        sample_d = sample_q;
        valid_d  = valid_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    step    = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                // mem_addr has been stable for a full cycle, so mem_data is settled.
                sample_d = bus.mem_data;
                valid_d  = 1'b1;
                state_d  = StValid;
                miss_inc = accept;
            end
            StValid: begin
                if (bus.sample_ready) begin
                    valid_d = 1'b0;
                    if (accept) begin
                        step    = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    miss_inc = accept;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_addr_d = step ? addr_calc : mem_addr_q;
        missed_d   = (miss_inc && (missed_q != '1)) ? missed_q + 1'b1 : missed_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            mem_addr_q <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            missed_q   <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            missed_q   <= missed_d;
        end
    end

    assign bus.mem_addr     = mem_addr_q;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign missed           = missed_q;

endmodule
